delta_engine: RTL and testbench



---
 rtl/bpc_pkg.sv | 28 ++
 rtl/delta_engine_if.sv | 53 +++++
 rtl/delta_lane.sv | 29 ++
 rtl/delta_engine.sv | 148 ++++++++++++++
 tb/tb_delta_engine.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/bpc_pkg.sv
// ---------------------------------------------------------------------------
// bpc_pkg
// Shared definitions for the bit-plane compression encoder datapath.
//   WORD_W    : word width in bits (only 16 is supported downstream)
//   LANES     : words per beat
//   BLK_BEATS : beats per compression block (power of two)
//   DATA_W    : beat width in bits
//   CNT_W     : width of a beat-in-block counter
// Lane ordering: lane k occupies bits [DATA_W-1-WORD_W*k -: WORD_W], so
// lane 0 sits in the most significant word and is the earliest word.
// ---------------------------------------------------------------------------
package bpc_pkg;

    localparam int WORD_W    = 16;
    localparam int LANES     = 4;
    localparam int BLK_BEATS = 16;
    localparam int DATA_W    = WORD_W * LANES;
    localparam int CNT_W     = $clog2(BLK_BEATS);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [DATA_W-1:0] beat_t;

    // Extract lane 'lane' from a beat (lane 0 = most significant word).
    function automatic word_t lane_slice(input beat_t beat, input int unsigned lane);
        return word_t'(beat >> (WORD_W * (LANES - 1 - lane)));
    endfunction

endpackage : bpc_pkg

// File: rtl/delta_engine_if.sv
// ---------------------------------------------------------------------------
// delta_engine_if
// Beat stream bundle around the delta-transform stage.
//   data_i/valid_i/ready_o : upstream side (raw beats in)
//   data_o/valid_o/ready_i : downstream side (delta beats out)
//   first_o/last_o         : block position of the beat on data_o
//   bypass_i               : only present when DELTA_BYPASS_EN is defined
// Modports: slave = the delta engine, master = its environment.
// ---------------------------------------------------------------------------
interface delta_engine_if;
    import bpc_pkg::*;

    beat_t data_i;
    logic  valid_i;
    logic  ready_o;
    beat_t data_o;
    logic  valid_o;
    logic  ready_i;
    logic  first_o;
    logic  last_o;
`ifdef DELTA_BYPASS_EN
    logic  bypass_i;
`endif

    modport slave (
        input  data_i,
        input  valid_i,
        output ready_o,
        output data_o,
        output valid_o,
        input  ready_i,
        output first_o,
`ifdef DELTA_BYPASS_EN
        input  bypass_i,
`endif
        output last_o
    );

    modport master (
        output data_i,
        output valid_i,
        input  ready_o,
        input  data_o,
        input  valid_o,
        output ready_i,
        input  first_o,
`ifdef DELTA_BYPASS_EN
        output bypass_i,
`endif
        input  last_o
    );

endinterface : delta_engine_if

// File: rtl/delta_lane.sv
// ---------------------------------------------------------------------------
// delta_lane
// Combinational single-lane delta: delta_o = base_i ? cur_i : cur_i - prev_i,
// with the subtraction wrapping modulo 2^WORD_W.
//   cur_i   : current word
//   prev_i  : preceding word in the chain
//   base_i  : pass cur_i through unchanged (block base word)
//   delta_o : transformed word
// ---------------------------------------------------------------------------
module delta_lane
    import bpc_pkg::*;
(
    input  word_t cur_i,
    input  word_t prev_i,
    input  logic  base_i,
    output word_t delta_o
);

    // Base select and wrapping difference.
    always_comb begin
        delta_o = cur_i;
        if (base_i) begin
            delta_o = cur_i;
        end else begin
            delta_o = cur_i - prev_i;
        end
    end

endmodule : delta_lane

// File: rtl/delta_engine.sv
// ---------------------------------------------------------------------------
// delta_engine
// Delta-transform stage feeding the sign-reduction engine. Blocks are
// BLK_BEATS beats of LANES words. Word 0 of a block passes through as base;
// every later word becomes its wrapping difference from the preceding word,
// with the chain carried across beats via the previous-word register.
// One registered output stage with valid/ready on both sides.
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : delta_engine_if.slave (data_i/valid_i/ready_o in,
//          data_o/valid_o/ready_i/first_o/last_o out)
// Optional build macro: DELTA_BYPASS_EN adds bus.bypass_i, sampled on
// accept of beat 0 and held for the block; a bypassed block passes raw.
// ---------------------------------------------------------------------------
module delta_engine
    import bpc_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    delta_engine_if.slave  bus
);

    logic             ready_s;
    logic             accept_s;
    logic             base_s;
    logic             last_beat_s;
    logic [CNT_W-1:0] cnt_r;
    word_t            prev_r;
    beat_t            data_r;
    logic             valid_r;
    logic             first_r;
    logic             last_r;
    word_t            lane_in_s   [LANES];
    word_t            lane_prev_s [LANES];
    word_t            lane_out_s  [LANES];
    beat_t            delta_s;
    beat_t            next_data_s;

    // The output register may take a new beat when empty or draining.
    assign ready_s     = ~valid_r | bus.ready_i;
    assign accept_s    = bus.valid_i & ready_s;
    assign base_s      = (cnt_r == CNT_W'(0));
    assign last_beat_s = (cnt_r == CNT_W'(BLK_BEATS - 1));

    // Lane 0 chains from the previous beat; other lanes chain within the beat.
    // Only lane 0 can be a block base word.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_in_s[k] = lane_slice(bus.data_i, k);
        if (k == 0) begin : g_head
            assign lane_prev_s[k] = prev_r;
            delta_lane u_lane (
                .cur_i   (lane_in_s[k]),
                .prev_i  (lane_prev_s[k]),
                .base_i  (base_s),
                .delta_o (lane_out_s[k])
            );
        end else begin : g_tail
            assign lane_prev_s[k] = lane_in_s[k-1];
            delta_lane u_lane (
                .cur_i   (lane_in_s[k]),
                .prev_i  (lane_prev_s[k]),
                .base_i  (1'b0),
                .delta_o (lane_out_s[k])
            );
        end
    end

    // Reassemble lane results into beat order (lane 0 in the top word).
    always_comb begin
        delta_s = '0;
        for (int k = 0; k < LANES; k++) begin
            delta_s[DATA_W-1-WORD_W*k -: WORD_W] = lane_out_s[k];
        end
    end

`ifdef DELTA_BYPASS_EN
    logic byp_blk_r;
    logic byp_s;

    // On beat 0 the live bypass_i decides; later beats use the latched value.
    always_comb begin
        byp_s = byp_blk_r;
        if (base_s) begin
            byp_s = bus.bypass_i;
        end else begin
            byp_s = byp_blk_r;
        end
    end

    // Select raw or transformed beat for the output register.
    always_comb begin
        next_data_s = delta_s;
        if (byp_s) begin
            next_data_s = bus.data_i;
        end else begin
            next_data_s = delta_s;
        end
    end

    // Latch the bypass decision for the whole block at beat 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byp_blk_r <= 1'b0;
        end else if (accept_s && base_s) begin
            byp_blk_r <= bus.bypass_i;
        end else begin
            byp_blk_r <= byp_blk_r;
        end
    end
`else
    // Every block is delta-transformed.
    always_comb begin
        next_data_s = delta_s;
    end
`endif

    // Output stage, beat counter and previous-word register.
    // Registers move only on accept; an output handshake without a new
    // accept just drops valid, leaving data/first/last as they were.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r  <= '0;
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            cnt_r   <= '0;
            prev_r  <= '0;
        end else if (accept_s) begin
            data_r  <= next_data_s;
            valid_r <= 1'b1;
            first_r <= base_s;
            last_r  <= last_beat_s;
            cnt_r   <= cnt_r + CNT_W'(1);
            prev_r  <= lane_in_s[LANES-1];
        end else if (valid_r && bus.ready_i) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    assign bus.ready_o = ready_s;
    assign bus.data_o  = data_r;
    assign bus.valid_o = valid_r;
    assign bus.first_o = first_r;
    assign bus.last_o  = last_r;

endmodule : delta_engine

// File: tb/tb_delta_engine.sv
// ---------------------------------------------------------------------------
// tb_delta_engine
// Directed plus randomized stimulus for delta_engine, checked against a
// word-level reference model (block position, previous word, output slot).
// ---------------------------------------------------------------------------
module tb_delta_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    delta_engine_if bus ();

    delta_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit          m_valid;
    logic [63:0] m_data;
    bit          m_first;
    bit          m_last;
    int          m_idx;
    int          m_prev;
    bit          m_byp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int wrap16(input int x);
        return ((x % 65536) + 65536) % 65536;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_data = 64'd0; m_first = 1'b0; m_last = 1'b0;
        m_idx = 0; m_prev = 0; m_byp = 1'b0;
    endtask

    // A beat is taken: compute the expected output from the word rules.
    task automatic model_accept(input logic [63:0] d, input bit b);
        int w [4];
        int o [4];
        bit raw;
        for (int k = 0; k < 4; k++) w[k] = int'(d[63-16*k -: 16]);
        if (m_idx == 0) m_byp = b;
        raw = m_byp;
        o[0] = (m_idx == 0) ? w[0] : wrap16(w[0] - m_prev);
        for (int k = 1; k < 4; k++) o[k] = wrap16(w[k] - w[k-1]);
        if (raw) m_data = d;
        else     m_data = {o[0][15:0], o[1][15:0], o[2][15:0], o[3][15:0]};
        m_first = (m_idx == 0);
        m_last  = (m_idx == 15);
        m_idx   = (m_idx + 1) % 16;
        m_prev  = w[3];
        m_valid = 1'b1;
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.valid_o), 64'(m_valid));
        chk({tag, "_data"},  bus.data_o,       m_data);
        chk({tag, "_first"}, 64'(bus.first_o), 64'(m_first));
        chk({tag, "_last"},  64'(bus.last_o),  64'(m_last));
    endtask

    // One clock: drive at negedge, check ready, step model, check after edge.
    task automatic cycle(input bit v, input logic [63:0] d, input bit r, input bit b,
                         output bit acc);
        bit exp_ready;
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
`ifdef DELTA_BYPASS_EN
        bus.bypass_i = b;
`endif
        #1;
        exp_ready = !m_valid || r;
        chk("ready_o", 64'(bus.ready_o), 64'(exp_ready));
        acc = v && exp_ready;
        if (acc) model_accept(d, b);
        else if (m_valid && r) m_valid = 1'b0;
        @(posedge clk);
        #1;
        chk_outputs("cyc");
        @(negedge clk);
    endtask

    initial begin : main
        bit          acc;
        logic [63:0] d;
        logic [63:0] snap;
        bit          pend_v;
        logic [63:0] pend_d;
        bit          v;
        bit          r;
        int          guard;

        bus.valid_i = 1'b0;
        bus.data_i  = 64'd0;
        bus.ready_i = 1'b0;
`ifdef DELTA_BYPASS_EN
        bus.bypass_i = 1'b0;
`endif
        model_reset();

        // Reset state.
        repeat (3) @(negedge clk);
        chk_outputs("reset");
        rst = 1'b0;

        // Block start and cross-beat chain.
        cycle(1'b1, 64'h0010_0012_0011_0015, 1'b1, 1'b0, acc);
        chk("tp_beat0_data",  bus.data_o, 64'h0010_0002_FFFF_0004);
        chk("tp_beat0_first", 64'(bus.first_o), 64'd1);
        cycle(1'b1, 64'h0015_0015_0014_0020, 1'b1, 1'b0, acc);
        chk("tp_beat1_data",  bus.data_o, 64'h0000_0000_FFFF_000C);
        chk("tp_beat1_first", 64'(bus.first_o), 64'd0);

        // Wrap arithmetic: load p = 0xFFFF then wrap across zero.
        cycle(1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0, acc);
        cycle(1'b1, 64'h0000_8000_7FFF_7FFF, 1'b1, 1'b0, acc);
        chk("tp_wrap_data", bus.data_o, 64'h0001_8000_FFFF_0000);

        // Beats 4..15, then beat 16 starts a new block.
        for (int i = 4; i < 16; i++) begin
            cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, acc);
        end
        chk("tp_beat15_last", 64'(bus.last_o), 64'd1);
        d = {16'hBEEF, 16'(($urandom)), 32'($urandom)};
        cycle(1'b1, d, 1'b1, 1'b0, acc);
        chk("tp_beat16_first", 64'(bus.first_o), 64'd1);
        chk("tp_beat16_base",  64'(bus.data_o[63:48]), 64'h0000_0000_0000_BEEF);
        chk("tp_beat16_last",  64'(bus.last_o), 64'd0);

        // Backpressure: one beat in, then stall 5 cycles with a beat waiting.
        cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, acc);
        snap = m_data;
        d = {$urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, d, 1'b0, 1'b0, acc);
            chk("bp_ready_low", 64'(bus.ready_o), 64'd0);
            chk("bp_stable", bus.data_o, snap);
        end
        cycle(1'b1, d, 1'b1, 1'b0, acc);
        chk("bp_release_acc", 64'(acc), 64'd1);
        cycle(1'b0, 64'd0, 1'b1, 1'b0, acc);
        chk("bp_drained", 64'(bus.valid_o), 64'd0);

        // Randomized traffic; upstream holds an unaccepted beat.
        pend_v = 1'b0;
        pend_d = 64'd0;
        for (int i = 0; i < 400; i++) begin
            if (pend_v) begin
                v = 1'b1;
                d = pend_d;
            end else begin
                v = ($urandom_range(0, 3) != 0);
                d = {$urandom, $urandom};
            end
            r = ($urandom_range(0, 3) != 0);
            cycle(v, d, r, 1'b0, acc);
            pend_v = v && !acc;
            pend_d = d;
        end
        // Flush any held beat.
        guard = 0;
        while (pend_v && guard < 8) begin
            cycle(1'b1, pend_d, 1'b1, 1'b0, acc);
            pend_v = !acc;
            guard++;
        end
        chk("rand_flush", 64'(pend_v), 64'd0);

        // Reset mid-block: bring the block to just after beat 7.
        guard = 0;
        while (m_idx != 8 && guard < 32) begin
            cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, acc);
            guard++;
        end
        chk("rst_align", 64'(m_idx), 64'd8);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk_outputs("rst_async");
        @(negedge clk);
        rst = 1'b0;
        d = {16'h1234, 16'h0001, 32'($urandom)};
        cycle(1'b1, d, 1'b1, 1'b0, acc);
        chk("rst_next_first", 64'(bus.first_o), 64'd1);
        chk("rst_next_base",  64'(bus.data_o[63:48]), 64'h0000_0000_0000_1234);
        chk("rst_next_lane1", 64'(bus.data_o[47:32]), 64'h0000_0000_0000_EDCD);

`ifdef DELTA_BYPASS_EN
        // Bypass latched at beat 0 covers the whole block.
        guard = 0;
        while (m_idx != 0 && guard < 32) begin
            cycle(1'b1, {$urandom, $urandom}, 1'b1, 1'b0, acc);
            guard++;
        end
        for (int i = 0; i < 16; i++) begin
            d = {$urandom, $urandom};
            cycle(1'b1, d, 1'b1, (i == 0), acc);
            chk("byp_raw", bus.data_o, d);
        end
        d = {$urandom, $urandom};
        cycle(1'b1, d, 1'b1, 1'b0, acc);
        chk("byp_off_first", 64'(bus.first_o), 64'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_delta_engine
